// File: rtl/pcihellocore_btn_conditioner_pkg.sv
// Shared constants for the PCI hello core button conditioner: board clock, default
// debounce time and button count, plus the debounce counter sizing helper.
package pcihellocore_btn_conditioner_pkg;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned DEBOUNCE_MS             = 10;
    localparam int unsigned BTN_WIDTH               = 32;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // A counter of this width holds 0 .. cycles-1 and is never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pcihellocore_btn_debounce_bit.sv
// One button bit: synchroniser chain, stable-time counter, debounced level and
// registered press/release pulses. Polarity is normalised by the parent.
module pcihellocore_btn_debounce_bit
    import pcihellocore_btn_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RELEASED_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic norm,
    output logic sync_out,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_event
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_d;
    logic                   release_event;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RELEASED_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Any cycle where norm agrees with the debounced level restarts the count.
    always_comb begin
        cnt_d         = cnt_q;
        level_d       = level;
        press_event   = 1'b0;
        release_event = 1'b0;
        if (norm == level) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d         = '0;
            level_d       = norm;
            press_event   = norm;
            release_event = ~norm;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            level         <= level_d;
            press_pulse   <= press_event;
            release_pulse <= release_event;
        end
    end

endmodule

// File: rtl/pcihellocore_btn_conditioner.sv
// Conditions raw board buttons for the PIO inputs: per-bit sync + debounce,
// pressed=1 polarity, press/release pulses and a software-clearable edge capture.
module pcihellocore_btn_conditioner
    import pcihellocore_btn_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH           = BTN_WIDTH,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    input  logic [WIDTH-1:0] clear_edges,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] edge_capture
);

    localparam logic RELEASED_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] press_event;

    assign norm = ACTIVE_LOW ? ~sync_out : sync_out;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_btn_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RELEASED_LEVEL  (RELEASED_LEVEL)
        ) u_bit (
            .clk           (clk),
            .reset_n       (reset_n),
            .raw           (btn_raw[i]),
            .norm          (norm[i]),
            .sync_out      (sync_out[i]),
            .level         (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .press_event   (press_event[i])
        );
    end

    // Set wins over a simultaneous clear so a press is never lost to a held clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= press_event | (edge_capture & ~clear_edges);
        end
    end

endmodule
